// File: rtl/dmem_ctrl.sv
// Data-memory responder: one load/store at a time, fixed-latency response held until accepted.
module dmem_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter              INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_uns,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        enter_resp;
  logic        accept;

  logic        lat_we, lat_uns;
  logic [1:0]  lat_width;
  logic [31:0] lat_addr, lat_wdata;

  logic        op_we, op_uns, op_err;
  logic [1:0]  op_width;
  logic [31:0] op_addr, op_wdata, op_off;
  logic [IDX_W-1:0] idx;

  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rd_word, sh_word, ext_word, load_data;

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  assign req_ready  = (state == IDLE) & ~rst;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;

  // With LATENCY==1 the memory access happens on the accept edge itself, so the
  // operation is taken straight from the request bus while IDLE.
  always_comb begin
    if (state == IDLE) begin
      op_we    = req_we;
      op_uns   = req_uns;
      op_width = req_width;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end else begin
      op_we    = lat_we;
      op_uns   = lat_uns;
      op_width = lat_width;
      op_addr  = lat_addr;
      op_wdata = lat_wdata;
    end
    op_off = op_addr - ADDR_BASE;
    op_err = (op_width == 2'b11)
           | ((op_width == 2'b01) & op_addr[0])
           | ((op_width == 2'b10) & (|op_addr[1:0]))
           | (op_off >= SPAN);
    idx    = op_off[IDX_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = CNT_LOAD;
          if (LATENCY == 1) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_uns   <= req_uns;
      lat_width <= req_width;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  always_comb begin
    be    = '0;
    wword = '0;
    unique case (op_width)
      2'b00: begin
        be[op_addr[1:0]] = 1'b1;
        wword            = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be    = op_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wword = op_wdata;
      end
      default: ;
    endcase
  end

  // Commit gated by rst so a store abandoned in WAIT never reaches the array.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_we && !op_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = mem[idx];
    sh_word  = rd_word >> {op_addr[1:0], 3'b000};
    ext_word = '0;
    unique case (op_width)
      2'b00: ext_word = op_uns ? {24'b0, sh_word[7:0]}
                               : {{24{sh_word[7]}}, sh_word[7:0]};
      2'b01: ext_word = op_uns ? {16'b0, sh_word[15:0]}
                               : {{16{sh_word[15]}}, sh_word[15:0]};
      2'b10: ext_word = rd_word;
      default: ext_word = '0;
    endcase
    load_data = (op_we | op_err) ? '0 : ext_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_rdata <= load_data;
      resp_err   <= op_err;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed spec scenarios plus randomized traffic
// checked against a byte-level reference memory model.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_width = '0;
    logic        req_uns = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  w;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_e;
    } vec_t;

    dmem_ctrl #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_width (req_width),
        .req_uns   (req_uns),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: RISC-V load/store semantics on a byte-addressed view of the array.
    task automatic ref_model(input logic we, input logic [31:0] addr, input logic [1:0] w,
                             input logic uns, input logic [31:0] wd,
                             output logic [31:0] rd, output logic e);
        logic [31:0] off, v;
        int          sh, i;
        off = addr - BASE;
        e   = (w == 2'd3) || (w == 2'd1 && addr % 2 != 0) ||
              (w == 2'd2 && addr % 4 != 0) || (off >= DEPTH * 4);
        rd  = 0;
        if (!e) begin
            i  = int'(off / 4);
            sh = int'(addr % 4) * 8;
            if (we) begin
                if (w == 2'd0)      mdl[i][sh +: 8]  = wd[7:0];
                else if (w == 2'd1) mdl[i][sh +: 16] = wd[15:0];
                else                mdl[i]           = wd;
            end else begin
                v = mdl[i] >> sh;
                if (w == 2'd0)      rd = uns ? (v & 32'hFF)   : 32'($signed(v[7:0]));
                else if (w == 2'd1) rd = uns ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
                else                rd = mdl[i];
            end
        end
    endtask

    // Drives one transaction; reports what the DUT did, no judgement.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] w,
                           input logic uns, input logic [31:0] wd, input int stall,
                           output int lat, output logic [31:0] rd, output logic e,
                           output bit stable, output bit rdy_low, output bit no_overlap);
        int guard;
        stable = 1; rdy_low = 1; no_overlap = 1; lat = -1; rd = '0; e = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_width = w;
        req_uns = uns; req_wdata = wd;
        @(posedge clk); #1;
        req_we = 1'($urandom); req_addr = $urandom; req_width = 2'($urandom);
        req_uns = 1'($urandom); req_wdata = $urandom;
        for (int j = 1; j <= 40; j++) begin
            req_valid = 1'($urandom);
            @(negedge clk);
            if (resp_valid) begin
                lat = j;
                break;
            end
            if (req_ready) rdy_low = 0;
        end
        if (lat < 0) begin
            req_valid = 1'b0;
            return;
        end
        rd = resp_rdata;
        e  = resp_err;
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1;
            if (req_ready) rdy_low = 0;
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rd || resp_err !== e) stable = 0;
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        if (req_ready) no_overlap = 0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clk);
        if (resp_valid || !req_ready) no_overlap = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low: got %b expected 0", req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
    endtask

    task automatic test_store_load();
        vec_t v[$];
        int lat; logic [31:0] rd, mrd; logic e, me; bit st, rl, no;
        v.push_back('{1'b1, 32'h1001_0004, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0});
        v.push_back('{1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, 32'h1001_0005, 2'd0, 1'b0, 32'hFFFF_FF80, 32'h0,       1'b0});
        v.push_back('{1'b0, 32'h1001_0005, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0});
        v.push_back('{1'b0, 32'h1001_0005, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0});
        v.push_back('{1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0});
        v.push_back('{1'b0, 32'h1001_0001, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, 32'h1001_0006, 2'd2, 1'b0, 32'h1111_1111, 32'h0,       1'b1});
        v.push_back('{1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0});
        v.push_back('{1'b0, 32'h1001_0006, 2'd1, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0});
        v.push_back('{1'b0, 32'h1001_0006, 2'd1, 1'b1, 32'h0,        32'h0000DEAD, 1'b0});
        v.push_back('{1'b0, 32'h1001_0004, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1});
        foreach (v[k]) begin
            run_txn(v[k].we, v[k].addr, v[k].w, v[k].uns, v[k].wd, 0, lat, rd, e, st, rl, no);
            ref_model(v[k].we, v[k].addr, v[k].w, v[k].uns, v[k].wd, mrd, me);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL store_load_latency[%0d]: got %0d expected %0d", k, lat, LAT);
            end
            checks++;
            if (rd !== v[k].exp_rd || e !== v[k].exp_e) begin
                failures++;
                $display("FAIL store_load_resp[%0d]: got rdata=%h err=%b expected rdata=%h err=%b",
                         k, rd, e, v[k].exp_rd, v[k].exp_e);
            end
        end
    endtask

    task automatic test_out_of_range();
        vec_t v[$];
        int lat; logic [31:0] rd, mrd; logic e, me; bit st, rl, no;
        v.push_back('{1'b0, 32'h1001_1000, 2'd2, 1'b0, 32'h0,         32'h0,        1'b1});
        v.push_back('{1'b0, 32'h1000_FFFC, 2'd2, 1'b0, 32'h0,         32'h0,        1'b1});
        v.push_back('{1'b1, 32'h1001_0FFE, 2'd1, 1'b0, 32'h0000_A5C3, 32'h0,        1'b0});
        v.push_back('{1'b0, 32'h1001_0FFE, 2'd1, 1'b0, 32'h0,         32'hFFFFA5C3, 1'b0});
        v.push_back('{1'b0, 32'h1001_0FFF, 2'd0, 1'b0, 32'h0,         32'hFFFFFFA5, 1'b0});
        v.push_back('{1'b0, 32'h1001_0FFC, 2'd2, 1'b0, 32'h0,         32'hA5C30000, 1'b0});
        v.push_back('{1'b1, 32'h1001_1000, 2'd0, 1'b0, 32'h0000_0077, 32'h0,        1'b1});
        v.push_back('{1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'h0,         32'h0,        1'b0});
        foreach (v[k]) begin
            run_txn(v[k].we, v[k].addr, v[k].w, v[k].uns, v[k].wd, 0, lat, rd, e, st, rl, no);
            ref_model(v[k].we, v[k].addr, v[k].w, v[k].uns, v[k].wd, mrd, me);
            checks++;
            if (lat !== LAT || rd !== v[k].exp_rd || e !== v[k].exp_e) begin
                failures++;
                $display("FAIL range[%0d]: got lat=%0d rdata=%h err=%b expected lat=%0d rdata=%h err=%b",
                         k, lat, rd, e, LAT, v[k].exp_rd, v[k].exp_e);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic e; bit st, rl, no;
        run_txn(1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0, 5, lat, rd, e, st, rl, no);
        checks++;
        if (lat !== LAT || rd !== 32'hDEAD80EF || e !== 1'b0) begin
            failures++;
            $display("FAIL bp_resp: got lat=%0d rdata=%h err=%b expected %0d DEAD80EF 0", lat, rd, e, LAT);
        end
        checks++;
        if (!st) begin
            failures++;
            $display("FAIL bp_stable: outputs changed while resp_ready low (got 0 expected 1)");
        end
        checks++;
        if (!rl) begin
            failures++;
            $display("FAIL bp_ready_low: req_ready high while busy (got 1 expected 0)");
        end
        checks++;
        if (!no) begin
            failures++;
            $display("FAIL bp_overlap: request accepted in response cycle (got 1 expected 0)");
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd, mrd; logic e, me; bit st, rl, no, saw;
        run_txn(1'b1, 32'h1001_0008, 2'd2, 1'b0, 32'h1234_5678, 0, lat, rd, e, st, rl, no);
        ref_model(1'b1, 32'h1001_0008, 2'd2, 1'b0, 32'h1234_5678, mrd, me);
        // store abandoned while in WAIT
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1001_0008; req_width = 2'd2;
        req_uns = 1'b0; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_busy: got ready=%b valid=%b expected 0 0", req_ready, resp_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) saw = 1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL rst_wait_idle: got response/busy after reset expected idle");
        end
        // response dropped by reset in RESP
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1001_0004; req_width = 2'd2; req_uns = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        saw = 0;
        for (int c = 0; c < 20 && !saw; c++) begin
            @(negedge clk);
            if (resp_valid) saw = 1;
        end
        checks++;
        if (!saw) begin
            failures++;
            $display("FAIL rst_resp_timeout: got no resp_valid expected 1");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_resp_drop: got valid=%b ready=%b rdata=%h err=%b expected 0 1 0 0",
                     resp_valid, req_ready, resp_rdata, resp_err);
        end
        run_txn(1'b0, 32'h1001_0008, 2'd2, 1'b0, 32'h0, 0, lat, rd, e, st, rl, no);
        checks++;
        if (lat !== LAT || rd !== 32'h1234_5678 || e !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_commit: got lat=%0d rdata=%h err=%b expected %0d 12345678 0", lat, rd, e, LAT);
        end
    endtask

    task automatic test_random();
        int lat, stall; logic [31:0] rd, mrd, addr, wd; logic e, me, we, uns; logic [1:0] w;
        bit st, rl, no;
        for (int n = 0; n < 120; n++) begin
            we   = 1'($urandom);
            w    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom);
            wd   = $urandom;
            case ($urandom_range(0, 9))
                0:       addr = BASE + $urandom_range(4090, 4200);
                1:       addr = BASE - $urandom_range(1, 16);
                default: addr = BASE + $urandom_range(0, 47);
            endcase
            stall = $urandom_range(0, 3);
            run_txn(we, addr, w, uns, wd, stall, lat, rd, e, st, rl, no);
            ref_model(we, addr, w, uns, wd, mrd, me);
            checks++;
            if (lat !== LAT || rd !== mrd || e !== me || !st || !rl || !no) begin
                failures++;
                $display("FAIL random[%0d] we=%b addr=%h w=%0d uns=%b: got lat=%0d rdata=%h err=%b st=%0d rl=%0d no=%0d expected lat=%0d rdata=%h err=%b 1 1 1",
                         n, we, addr, w, uns, lat, rd, e, st, rl, no, LAT, mrd, me);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
